// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one Avalon-MM SDRAM controller port between a video master (m0) and a logic master (m1).
// Define SDRAM_ARB_RR_EN for round-robin arbitration instead of fixed priority with a starvation guard.
module sdram_port_arbiter #(
  parameter int ADDR_W       = 25,
  parameter int DATA_W       = 16,
  parameter int MAX_PEND     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic                s_waitrequest,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_readdatavalid,
  output logic                err_orphan,
  output logic                dbg_state
);
  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_PEND);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  // Masters: command held until mN_waitrequest is seen low for one cycle.
  // Slave: command held on s_read/s_write until s_waitrequest is low.
  state_t            state_q;
  logic [ADDR_W-1:0] s_address_q;
  logic [DATA_W-1:0] s_writedata_q;
  logic [BE_W-1:0]   s_byteenable_q;
  logic              s_read_q, s_write_q, owner_q;
  logic              m0_wait_q, m1_wait_q, m0_rdv_q, m1_rdv_q, err_q;
  logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;
  logic              tag_q [MAX_PEND];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              m0_rd, m0_wr, m1_rd, m1_wr, elig0, elig1, grant1, grant_any, push, pop;

`ifdef SDRAM_ARB_RR_EN
  logic last_q;
`else
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);
  logic [SW-1:0] starve_q;
  logic          m1_req;
`endif

  always_comb begin
    // A simultaneous read+write is treated as a read.
    m0_rd = m0_read;
    m0_wr = m0_write & ~m0_read;
    m1_rd = m1_read;
    m1_wr = m1_write & ~m1_read;
    elig0 = m0_rd ? (count_q != FULL) : m0_wr;
    elig1 = m1_rd ? (count_q != FULL) : m1_wr;
`ifdef SDRAM_ARB_RR_EN
    grant1 = elig1 & (~elig0 | ~last_q);
`else
    m1_req = m1_read | m1_write;
    grant1 = elig1 & (~elig0 | (starve_q == SLIM));
`endif
    grant_any = (state_q == IDLE) & (elig0 | elig1);
    push      = (state_q == ISSUE) & ~s_waitrequest & s_read_q;
    pop       = s_readdatavalid & (count_q != '0);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q        <= IDLE;
      s_address_q    <= '0;
      s_writedata_q  <= '0;
      s_byteenable_q <= '0;
      s_read_q       <= 1'b0;
      s_write_q      <= 1'b0;
      owner_q        <= 1'b0;
      m0_wait_q      <= 1'b1;
      m1_wait_q      <= 1'b1;
      m0_rdv_q       <= 1'b0;
      m1_rdv_q       <= 1'b0;
      m0_rdata_q     <= '0;
      m1_rdata_q     <= '0;
      err_q          <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      for (int i = 0; i < MAX_PEND; i++) tag_q[i] <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
      last_q         <= 1'b1;
`else
      starve_q       <= '0;
`endif
    end else begin
      m0_wait_q <= 1'b1;
      m1_wait_q <= 1'b1;
      m0_rdv_q  <= 1'b0;
      m1_rdv_q  <= 1'b0;
      count_q   <= count_d;
      case (state_q)
        IDLE: if (grant_any) begin
          state_q <= ISSUE;
          owner_q <= grant1;
          if (grant1) begin
            s_address_q    <= m1_address;
            s_writedata_q  <= m1_writedata;
            s_byteenable_q <= m1_byteenable;
            s_read_q       <= m1_rd;
            s_write_q      <= m1_wr;
            m1_wait_q      <= 1'b0;
          end else begin
            s_address_q    <= m0_address;
            s_writedata_q  <= m0_writedata;
            s_byteenable_q <= m0_byteenable;
            s_read_q       <= m0_rd;
            s_write_q      <= m0_wr;
            m0_wait_q      <= 1'b0;
          end
        end
        ISSUE: if (!s_waitrequest) begin
          s_read_q  <= 1'b0;
          s_write_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
      if (push) begin
        tag_q[wr_ptr_q] <= owner_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      // Responses come back in issue order, so the oldest tag owns this beat.
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        if (tag_q[rd_ptr_q]) begin
          m1_rdv_q   <= 1'b1;
          m1_rdata_q <= s_readdata;
        end else begin
          m0_rdv_q   <= 1'b1;
          m0_rdata_q <= s_readdata;
        end
      end
      if (s_readdatavalid && (count_q == '0)) err_q <= 1'b1;
`ifdef SDRAM_ARB_RR_EN
      if (grant_any) last_q <= grant1;
`else
      if (!m1_req) starve_q <= '0;
      else if (grant_any) begin
        if (grant1) starve_q <= '0;
        else if (starve_q != SLIM) starve_q <= starve_q + 1'b1;
      end
`endif
    end
  end

  assign s_address        = s_address_q;
  assign s_writedata      = s_writedata_q;
  assign s_byteenable     = s_byteenable_q;
  assign s_read           = s_read_q;
  assign s_write          = s_write_q;
  assign m0_waitrequest   = m0_wait_q;
  assign m1_waitrequest   = m1_wait_q;
  assign m0_readdata      = m0_rdata_q;
  assign m1_readdata      = m1_rdata_q;
  assign m0_readdatavalid = m0_rdv_q;
  assign m1_readdatavalid = m1_rdv_q;
  assign err_orphan       = err_q;
  assign dbg_state        = state_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: randomized scoreboard bench for sdram_port_arbiter with a slave model and response routing model.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;
  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;
  localparam int BE_W   = 2;

  logic              clk_clk = 1'b0;
  logic              reset_reset_n = 1'b0;
  logic [ADDR_W-1:0] m0_address = '0, m1_address = '0;
  logic              m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [DATA_W-1:0] m0_writedata = '0, m1_writedata = '0;
  logic [BE_W-1:0]   m0_byteenable = '0, m1_byteenable = '0;
  logic              m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic [ADDR_W-1:0] s_address;
  logic              s_read, s_write;
  logic [DATA_W-1:0] s_writedata;
  logic [BE_W-1:0]   s_byteenable;
  logic              s_waitrequest = 1'b1;
  logic [DATA_W-1:0] s_readdata = '0;
  logic              s_readdatavalid = 1'b0;
  logic              err_orphan, dbg_state;

  sdram_port_arbiter dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .err_orphan(err_orphan), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk_clk = ~clk_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int                id;
    logic              rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
  } cmd_t;
  typedef struct {
    int                id;
    logic [DATA_W-1:0] data;
    int                due;
  } resp_t;

  cmd_t  exp_cmd_q[$];
  resp_t resp_q[$];
  int    grant_log[$];
  int    checks = 0, errors = 0, cyc = 0;
  bit    hold = 0, always_ready = 0, inject_orphan = 0, fdata_en = 0, err_exp = 0;
  int    fixed_delay = -1;
  logic [DATA_W-1:0] fdata = '0;
  int    exp_rdv_id = -1;
  logic [DATA_W-1:0] exp_rdv_data = '0;
  bit    prev_s_acc = 0, prev_w0_low = 0, prev_w1_low = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic m_drive(input int id, input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    if (id == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
    end
  endtask

  task automatic m_idle(input int id);
    m_drive(id, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // Present a command, wait for its one-cycle acceptance, return one cycle later.
  task automatic m_cmd(input int id, input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    bit ok = 0;
    m_drive(id, rd, wr, a, d, be);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_clk);
      if (((id == 0) ? m0_waitrequest : m1_waitrequest) == 1'b0) begin
        ok = 1;
        break;
      end
    end
    chk($sformatf("m%0d_accept_timeout", id), ok, 1);
    @(negedge clk_clk);
  endtask

  task automatic m_random(input int id, input int n);
    for (int k = 0; k < n; k++) begin
      int op = $urandom_range(0, 9);
      m_cmd(id, (op < 5) || (op == 9), op >= 5, ADDR_W'($urandom), DATA_W'($urandom), BE_W'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        m_idle(id);
        repeat ($urandom_range(1, 3)) @(negedge clk_clk);
      end
    end
    m_idle(id);
  endtask

  task automatic m_reads(input int id, input int n);
    for (int k = 0; k < n; k++) m_cmd(id, 1'b1, 1'b0, ADDR_W'($urandom), '0, '1);
    m_idle(id);
  endtask

  // Slave model + scoreboard monitor
  cmd_t  c;
  resp_t r;
  always @(negedge clk_clk) begin
    #1;
    if (!reset_reset_n) begin
      exp_cmd_q.delete();
      resp_q.delete();
      err_exp = 0; exp_rdv_id = -1; prev_s_acc = 0; prev_w0_low = 0; prev_w1_low = 0;
      s_waitrequest = 1'b1; s_readdatavalid = 1'b0;
    end else begin
      cyc++;
      chk("m0_readdatavalid", m0_readdatavalid, exp_rdv_id == 0);
      chk("m1_readdatavalid", m1_readdatavalid, exp_rdv_id == 1);
      if (exp_rdv_id == 0) chk("m0_readdata", m0_readdata, exp_rdv_data);
      if (exp_rdv_id == 1) chk("m1_readdata", m1_readdata, exp_rdv_data);
      chk("err_orphan", err_orphan, err_exp);

      if (prev_w0_low) chk("m0_waitrequest_one_cycle", m0_waitrequest, 1);
      if (prev_w1_low) chk("m1_waitrequest_one_cycle", m1_waitrequest, 1);
      if (!m0_waitrequest) begin
        chk("m0_accept_without_request", m0_read | m0_write, 1);
        c.id = 0; c.rd = m0_read; c.addr = m0_address; c.data = m0_writedata; c.be = m0_byteenable;
        exp_cmd_q.push_back(c);
        grant_log.push_back(0);
      end
      if (!m1_waitrequest) begin
        chk("m1_accept_without_request", m1_read | m1_write, 1);
        c.id = 1; c.rd = m1_read; c.addr = m1_address; c.data = m1_writedata; c.be = m1_byteenable;
        exp_cmd_q.push_back(c);
        grant_log.push_back(1);
      end
      prev_w0_low = !m0_waitrequest;
      prev_w1_low = !m1_waitrequest;

      if (prev_s_acc) chk("cmd_spacing", {s_read, s_write}, 0);
      prev_s_acc = 0;
      s_waitrequest = always_ready ? 1'b0 : ($urandom_range(0, 2) == 0);
      if (s_read || s_write) begin
        if (exp_cmd_q.size() == 0) chk("spurious_slave_cmd", {s_read, s_write}, 0);
        else begin
          c = exp_cmd_q[0];
          chk("s_read", s_read, c.rd);
          chk("s_write", s_write, !c.rd);
          chk("s_address", s_address, c.addr);
          if (!c.rd) begin
            chk("s_writedata", s_writedata, c.data);
            chk("s_byteenable", s_byteenable, c.be);
          end
          if (!s_waitrequest) begin
            void'(exp_cmd_q.pop_front());
            prev_s_acc = 1;
            if (c.rd) begin
              r.id = c.id;
              r.data = fdata_en ? fdata : DATA_W'($urandom);
              r.due = cyc + ((fixed_delay >= 0) ? fixed_delay : $urandom_range(1, 3));
              resp_q.push_back(r);
            end
          end
        end
      end

      exp_rdv_id = -1;
      s_readdatavalid = 1'b0;
      s_readdata = DATA_W'($urandom);
      if (inject_orphan) begin
        s_readdatavalid = 1'b1;
        err_exp = 1;
        inject_orphan = 0;
      end else if (!hold && resp_q.size() > 0 && resp_q[0].due <= cyc) begin
        r = resp_q.pop_front();
        s_readdatavalid = 1'b1;
        s_readdata = r.data;
        exp_rdv_id = r.id;
        exp_rdv_data = r.data;
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (resp_q.size() == 0 && exp_cmd_q.size() == 0) break;
      @(negedge clk_clk);
    end
    chk("drain_resp_q", resp_q.size(), 0);
    chk("drain_cmd_q", exp_cmd_q.size(), 0);
    repeat (3) @(negedge clk_clk);
  endtask

  bit done1, done5;
  initial begin
    repeat (3) @(negedge clk_clk);
    chk("rst_m0_waitrequest", m0_waitrequest, 1);
    chk("rst_m1_waitrequest", m1_waitrequest, 1);
    chk("rst_s_read", s_read, 0);
    chk("rst_s_write", s_write, 0);
    chk("rst_s_address", s_address, 0);
    chk("rst_s_writedata", s_writedata, 0);
    chk("rst_s_byteenable", s_byteenable, 0);
    chk("rst_m0_readdatavalid", m0_readdatavalid, 0);
    chk("rst_m1_readdatavalid", m1_readdatavalid, 0);
    chk("rst_m0_readdata", m0_readdata, 0);
    chk("rst_m1_readdata", m1_readdata, 0);
    chk("rst_err_orphan", err_orphan, 0);
    reset_reset_n = 1'b1;
    repeat (2) @(negedge clk_clk);

    // Single write from m0, then a single m1 read answered three cycles after acceptance.
    m_cmd(0, 1'b0, 1'b1, 25'h0000100, 16'hBEEF, 2'b11);
    m_idle(0);
    drain();
    fdata_en = 1; fdata = 16'h1234; fixed_delay = 3;
    m_cmd(1, 1'b1, 1'b0, 25'h0000200, '0, 2'b11);
    m_idle(1);
    drain();
    fdata_en = 0; fixed_delay = -1;

    // Both masters streaming reads with an always-ready slave.
    always_ready = 1;
    grant_log.delete();
    fork
      m_reads(0, 24);
      m_reads(1, 3);
    join
    drain();
    chk("grant_count", grant_log.size(), 27);
`ifdef SDRAM_ARB_RR_EN
    for (int i = 1; i < 6; i++) chk($sformatf("rr_alternate_%0d", i), grant_log[i] != grant_log[i-1], 1);
`else
    for (int i = 0; i < 27; i++) chk($sformatf("grant_pattern_%0d", i), grant_log[i], (i % 9) == 8);
`endif

    // Four reads outstanding: a fifth read stalls while a write from m1 still goes through.
    hold = 1;
    for (int k = 0; k < 4; k++) m_cmd(0, 1'b1, 1'b0, ADDR_W'(k), '0, '1);
    m_idle(0);
    done1 = 0; done5 = 0;
    fork
      begin m_cmd(0, 1'b1, 1'b0, 25'h0000555, '0, '1); done5 = 1; m_idle(0); end
      begin m_cmd(1, 1'b0, 1'b1, 25'h0000777, 16'hA5A5, 2'b01); done1 = 1; m_idle(1); end
    join_none
    repeat (12) @(negedge clk_clk);
    chk("stall_m1_write_done", done1, 1);
    chk("stall_fifth_read_blocked", done5, 0);
    chk("stall_m0_waitrequest", m0_waitrequest, 1);
    hold = 0;
    for (int i = 0; i < 100 && !done5; i++) @(negedge clk_clk);
    chk("stall_released", done5, 1);
    wait fork;
    always_ready = 0;
    drain();

    // Simultaneous read+write counts as a read.
    m_cmd(1, 1'b1, 1'b1, 25'h0000321, 16'hFFFF, 2'b11);
    m_idle(1);
    drain();

    // Randomized interleaved traffic from both masters.
    fork
      m_random(0, 60);
      m_random(1, 60);
    join
    drain();

    // Orphan response, then asynchronous reset clears the sticky flag.
    inject_orphan = 1;
    repeat (3) @(negedge clk_clk);
    chk("orphan_sticky", err_orphan, 1);
    #3 reset_reset_n = 1'b0;
    #1;
    chk("async_rst_err_orphan", err_orphan, 0);
    chk("async_rst_m0_waitrequest", m0_waitrequest, 1);
    chk("async_rst_s_read", s_read, 0);
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    repeat (4) @(negedge clk_clk);
    chk("final_err_orphan", err_orphan, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
Shares the single Avalon-MM SDRAM controller port in the SoC between two requesters. Port 0 is the video frame fetch (high priority); port 1 is the game-logic/bridge master. Commands are registered and issued one at a time. Read responses are routed back to the owning master through an outstanding-read tag FIFO. Sits between the fabric masters and the SDRAM controller slave.

Parameters:
ADDR_W, 25, word address width (32M x 16 SDRAM)
DATA_W, 16, data width; byteenable width = DATA_W/8
MAX_PEND, 4, max outstanding reads (tag FIFO depth, power of 2)
STARVE_LIMIT, 8, consecutive port-0 grants while port 1 waits before port 1 is forced

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  asynchronous active-low reset
mN_address  in  ADDR_W  master N address (N = 0,1; each mN_ port exists per master)
mN_read  in  1  master N read request
mN_write  in  1  master N write request
mN_writedata  in  DATA_W  master N write data
mN_byteenable  in  DATA_W/8  master N byte enables
mN_waitrequest  out  1  low for exactly the cycle master N's command is accepted
mN_readdata  out  DATA_W  routed read data
mN_readdatavalid  out  1  routed read-data strobe
s_address  out  ADDR_W  to SDRAM controller
s_read  out  1  to SDRAM controller
s_write  out  1  to SDRAM controller
s_writedata  out  DATA_W  to SDRAM controller
s_byteenable  out  DATA_W/8  to SDRAM controller
s_waitrequest  in  1  from SDRAM controller
s_readdata  in  DATA_W  from SDRAM controller
s_readdatavalid  in  1  from SDRAM controller
err_orphan  out  1  sticky: readdatavalid received with tag FIFO empty

Behaviour:
- Reset values: mN_waitrequest=1, s_read=s_write=0, s_address/s_writedata=0, s_byteenable=0, mN_readdatavalid=0, mN_readdata=0, err_orphan=0, tag FIFO empty, starve counter 0, FSM IDLE.
- Clock and reset: single clock domain clk_clk; reset_reset_n asynchronous active-low, synchronous deassertion handled upstream.
- FSM IDLE: eligible master = (read or write asserted) AND (write OR tag count < MAX_PEND). If none eligible, stay. Otherwise pick winner, latch its command into s_* registers, drive winner's mN_waitrequest=0 for that one cycle, go ISSUE.
- Winner selection (default): port 1 if starve counter == STARVE_LIMIT and port 1 eligible; else port 0 if eligible; else port 1.
- Starve counter: increments on a port-0 grant while port 1 has a request asserted; clears on any port-1 grant or when port 1 has no request; saturates at STARVE_LIMIT.
- FSM ISSUE: s_read/s_write held with latched command. When s_waitrequest==0, deassert s_read/s_write the next cycle; on a read, push tag (winner id) into FIFO; go IDLE. Minimum command spacing is 2 cycles.
- Master read+write both asserted: protocol violation; treated as read.
- Read response: when s_readdatavalid=1, pop tag; next cycle drive mT_readdata=s_readdata and mT_readdatavalid=1 for tag T only; fixed 1-cycle latency. The other master's readdatavalid stays 0.
- Push and pop in the same cycle: count unchanged, both take effect.
- FIFO full (count==MAX_PEND): reads not eligible; writes still eligible.
- s_readdatavalid with FIFO empty: data dropped, err_orphan set until reset.
- Reset mid-operation: in-flight command aborted, tags discarded; responses arriving after reset set err_orphan.

Optional Feature:
SDRAM_ARB_RR_EN: when defined, winner selection is strict round-robin: the last-granted port has lowest priority on the next contention, and the starve counter is not implemented. When undefined, the fixed-priority plus STARVE_LIMIT scheme above applies.

Test Plan:
- Reset, then m0 write addr 0x0000100 data 0xBEEF be=2'b11 -> m0_waitrequest low 1 cycle; s_write=1 with address 0x0000100 until s_waitrequest=0; no tag pushed.
- m1 read 0x0000200, slave returns 0x1234 three cycles after accept -> m1_readdatavalid=1 with 0x1234 exactly one cycle after s_readdatavalid; m0_readdatavalid stays 0.
- m0 and m1 request reads continuously, slave always ready, default build -> grant pattern 8 x m0 then 1 x m1 repeating; with SDRAM_ARB_RR_EN -> alternating m0/m1.
- Issue 4 reads, slave withholds readdatavalid -> 5th read stalls (waitrequest high, s_read=0) while a concurrent m1 write is still issued; first response releases the stall.
- Interleaved m0/m1 reads, returned in order with push/pop in the same cycle -> each datum reaches the correct master; FIFO count is correct throughout.
- Inject s_readdatavalid with no reads outstanding -> err_orphan=1 and no mN_readdatavalid pulse; reset_reset_n low clears it asynchronously.
